// File: rtl/sea_battle_pkg.sv
// Shared scan-code constants and prefix-decoder state type for the grid cursor.
package sea_battle_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;  // extended prefix
  localparam logic [7:0] SC_F0    = 8'hF0;  // break prefix
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } key_state_t;

  // True for bytes that only modify how the next byte is interpreted.
  function automatic logic is_prefix(input logic [7:0] code);
    return (code == SC_E0) || (code == SC_F0);
  endfunction

endpackage

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 prefix tracker; turns make codes into one-cycle key strobes.
//
// state      | meaning
// -----------+------------------------------------------
// ST_IDLE    | no prefix pending
// ST_EXT     | E0 seen, next non-prefix byte is a make
// ST_BRK     | F0 seen, next non-prefix byte is a break
// ST_EXT_BRK | E0 F0 seen, next non-prefix byte is a break
module ps2_key_decoder
  import sea_battle_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_code,
  input  logic       key_valid,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic       enter
);

  key_state_t state;
  logic       is_make;

  // Prefix state advances only on qualified bytes; reset wins over key_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (key_valid) begin
      if (key_code == SC_E0) begin
        state <= (state == ST_IDLE || state == ST_EXT) ? ST_EXT : ST_IDLE;
      end else if (key_code == SC_F0) begin
        state <= (state == ST_IDLE || state == ST_BRK) ? ST_BRK : ST_EXT_BRK;
      end else begin
        state <= ST_IDLE;
      end
    end
  end

  // Strobes are decoded from the current byte so the cursor moves on the same edge.
  always_comb begin
    is_make    = key_valid && !is_prefix(key_code) &&
                 (state == ST_IDLE || state == ST_EXT);
    move_up    = is_make && (key_code == SC_UP);
    move_down  = is_make && (key_code == SC_DOWN);
    move_left  = is_make && (key_code == SC_LEFT);
    move_right = is_make && (key_code == SC_RIGHT);
    enter      = is_make && (key_code == SC_ENTER);
  end

endmodule

// File: rtl/cursor_grid_ctrl.sv
// Grid cursor driven by PS/2 arrow keys; tracks cell index and pixel origin.
module cursor_grid_ctrl
  import sea_battle_pkg::*;
#(
  parameter int GRID_X    = 320,
  parameter int GRID_Y    = 50,
  parameter int CELL_SIZE = 30,
  parameter int COLS      = 10,
  parameter int ROWS      = 10,
  parameter int WRAP_EN   = 0,
  parameter int CW        = $clog2(COLS),
  parameter int RW        = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    key_code,
  input  logic          key_valid,
  input  logic          enable,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic [9:0]    cursor_x,
  output logic [9:0]    cursor_y,
  output logic          select_valid,
  output logic [CW-1:0] select_col,
  output logic [RW-1:0] select_row
);

  // The far edge of the grid must stay inside the 10-bit pixel space.
  if (GRID_X + COLS * CELL_SIZE > 1023) begin : g_bad_x
    $error("cursor_grid_ctrl: grid exceeds 10-bit x range");
  end
  if (GRID_Y + ROWS * CELL_SIZE > 1023) begin : g_bad_y
    $error("cursor_grid_ctrl: grid exceeds 10-bit y range");
  end

  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [9:0]    X_MIN   = 10'(GRID_X);
  localparam logic [9:0]    Y_MIN   = 10'(GRID_Y);
  localparam logic [9:0]    X_MAX   = 10'(GRID_X + (COLS - 1) * CELL_SIZE);
  localparam logic [9:0]    Y_MAX   = 10'(GRID_Y + (ROWS - 1) * CELL_SIZE);
  localparam logic [9:0]    STEP    = 10'(CELL_SIZE);

  logic move_up, move_down, move_left, move_right, enter;

  ps2_key_decoder u_dec (
    .clk        (clk),
    .rst        (rst),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .move_up    (move_up),
    .move_down  (move_down),
    .move_left  (move_left),
    .move_right (move_right),
    .enter      (enter)
  );

  // Index and pixel origin step together so no multiplier is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      col      <= '0;
      row      <= '0;
      cursor_x <= X_MIN;
      cursor_y <= Y_MIN;
    end else if (enable) begin
      if (move_left) begin
        if (col != '0) begin
          col      <= col - 1'b1;
          cursor_x <= cursor_x - STEP;
        end else if (WRAP_EN != 0) begin
          col      <= COL_MAX;
          cursor_x <= X_MAX;
        end
      end else if (move_right) begin
        if (col != COL_MAX) begin
          col      <= col + 1'b1;
          cursor_x <= cursor_x + STEP;
        end else if (WRAP_EN != 0) begin
          col      <= '0;
          cursor_x <= X_MIN;
        end
      end else if (move_up) begin
        if (row != '0) begin
          row      <= row - 1'b1;
          cursor_y <= cursor_y - STEP;
        end else if (WRAP_EN != 0) begin
          row      <= ROW_MAX;
          cursor_y <= Y_MAX;
        end
      end else if (move_down) begin
        if (row != ROW_MAX) begin
          row      <= row + 1'b1;
          cursor_y <= cursor_y + STEP;
        end else if (WRAP_EN != 0) begin
          row      <= '0;
          cursor_y <= Y_MIN;
        end
      end
    end
  end

  // Enter is acted on immediately or dropped; nothing is held for later.
  always_ff @(posedge clk) begin
    if (rst) begin
      select_valid <= 1'b0;
      select_col   <= '0;
      select_row   <= '0;
    end else begin
      select_valid <= enable && enter;
      if (enable && enter) begin
        select_col <= col;
        select_row <= row;
      end
    end
  end

endmodule

// File: tb/tb_cursor_grid_ctrl.sv
// Directed bench: one saturating and one wrapping instance share the stimulus.
module tb_cursor_grid_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] key_code = 8'h00;
  logic       key_valid = 1'b0;
  logic       enable = 1'b1;

  logic [3:0] col0, row0, scol0, srow0;
  logic [9:0] x0, y0;
  logic       sv0;
  logic [3:0] col1, row1, scol1, srow1;
  logic [9:0] x1, y1;
  logic       sv1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cursor_grid_ctrl #(.WRAP_EN(0)) dut0 (
    .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid), .enable(enable),
    .col(col0), .row(row0), .cursor_x(x0), .cursor_y(y0),
    .select_valid(sv0), .select_col(scol0), .select_row(srow0)
  );

  cursor_grid_ctrl #(.WRAP_EN(1)) dut1 (
    .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid), .enable(enable),
    .col(col1), .row(row1), .cursor_x(x1), .cursor_y(y1),
    .select_valid(sv1), .select_col(scol1), .select_row(srow1)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Present one byte for a single cycle; returns at the negedge after it was sampled.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    key_code  = b;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_col", int'(col0), 0);
    check("rst_row", int'(row0), 0);
    check("rst_x", int'(x0), 320);
    check("rst_y", int'(y0), 50);
    check("rst_sv", int'(sv0), 0);
    check("rst_scol", int'(scol0), 0);
    check("rst_srow", int'(srow0), 0);

    // extended right arrow moves, extended break does not
    send(8'hE0); send(8'h74);
    check("ext_right_col", int'(col0), 1);
    check("ext_right_x", int'(x0), 350);
    send(8'hE0); send(8'hF0); send(8'h74);
    check("ext_break_col", int'(col0), 1);
    check("ext_break_x", int'(x0), 350);

    // left at col 0, then twelve rights
    do_reset();
    send(8'h6B);
    check("sat_left_col", int'(col0), 0);
    check("sat_left_x", int'(x0), 320);
    check("wrap_left_col", int'(col1), 9);
    check("wrap_left_x", int'(x1), 590);
    repeat (12) send(8'h74);
    check("sat_right_col", int'(col0), 9);
    check("sat_right_x", int'(x0), 590);
    check("wrap_right_col", int'(col1), 1);
    check("wrap_right_x", int'(x1), 350);

    // vertical edges
    do_reset();
    send(8'h75);
    check("wrap_up_row", int'(row1), 9);
    check("wrap_up_y", int'(y1), 320);
    check("sat_up_row", int'(row0), 0);
    check("sat_up_y", int'(y0), 50);
    send(8'h72);
    check("wrap_down_row", int'(row1), 0);
    check("wrap_down_y", int'(y1), 50);
    check("sat_down_row", int'(row0), 1);
    check("sat_down_y", int'(y0), 80);

    // select at (3,4)
    do_reset();
    repeat (3) send(8'h74);
    repeat (4) send(8'h72);
    check("pos_x", int'(x0), 410);
    check("pos_y", int'(y0), 170);
    send(8'h5A);
    check("sel_pulse", int'(sv0), 1);
    check("sel_col", int'(scol0), 3);
    check("sel_row", int'(srow0), 4);
    @(negedge clk);
    check("sel_one_cycle", int'(sv0), 0);
    send(8'hF0); send(8'h5A);
    check("sel_break_none", int'(sv0), 0);
    check("sel_break_col", int'(scol0), 3);

    // disabled keys are dropped for good
    enable = 1'b0;
    send(8'h74);
    send(8'h5A);
    check("dis_col", int'(col0), 3);
    check("dis_sv", int'(sv0), 0);
    enable = 1'b1;
    @(negedge clk);
    check("reen_sv", int'(sv0), 0);
    check("reen_col", int'(col0), 3);

    // reset coincident with a key, after a pending prefix
    send(8'hE0);
    @(negedge clk);
    rst = 1'b1; key_code = 8'h74; key_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; key_valid = 1'b0;
    check("rstkey_col", int'(col0), 0);
    check("rstkey_row", int'(row0), 0);
    check("rstkey_x", int'(x0), 320);
    check("rstkey_y", int'(y0), 50);
    check("rstkey_scol", int'(scol0), 0);
    send(8'hF0); send(8'h74);
    check("post_break_col", int'(col0), 0);
    send(8'h74);
    check("post_make_col", int'(col0), 1);
    check("post_make_x", int'(x0), 350);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cursor_grid_ctrl.md
CURSOR_GRID_CTRL -- requirements
Module: cursor_grid_ctrl

Interface
REQ-001 SHALL have parameter GRID_X, default 320: pixel x of grid left edge.
REQ-002 SHALL have parameter GRID_Y, default 50: pixel y of grid top edge.
REQ-003 SHALL have parameter CELL_SIZE, default 30: cell pitch in pixels.
REQ-004 SHALL have parameter COLS, default 10: grid columns (>=2).
REQ-005 SHALL have parameter ROWS, default 10: grid rows (>=2).
REQ-006 SHALL have parameter WRAP_EN, default 0: 1 = edge moves wrap, 0 = edge moves saturate.
REQ-007 Ports: clk  in  1  single clock; all logic on its rising edge.
REQ-008 Ports: rst  in  1  reset, synchronous, active-high.
REQ-009 Ports: key_code  in  8  PS/2 set-2 scan byte.
REQ-010 Ports: key_valid  in  1  one-cycle strobe qualifying key_code.
REQ-011 Ports: enable  in  1  1 = moves and selects permitted.
REQ-012 Ports: col  out  CW=$clog2(COLS)  cursor column index.
REQ-013 Ports: row  out  RW=$clog2(ROWS)  cursor row index.
REQ-014 Ports: cursor_x, cursor_y  out  10 each  pixel top-left of cursor cell.
REQ-015 Ports: select_valid  out  1  one-cycle pulse on accepted Enter.
REQ-016 Ports: select_col, select_row  out  CW, RW  cell latched at select.

Function
REQ-017 Prefix FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
REQ-018 Transitions, on key_valid only: E0 -> EXT from IDLE/EXT; F0 -> BRK from IDLE/BRK, -> EXT_BRK from EXT/EXT_BRK; any other byte -> IDLE.
REQ-019 Non-prefix byte in IDLE or EXT = make code; in BRK or EXT_BRK = break code, ignored except for returning to IDLE.
REQ-020 Make codes 75/72/6B/74 = up/down/left/right, accepted with or without E0; 5A = Enter; all others ignored.
REQ-021 Accepted move updates col/row and cursor_x/cursor_y on the clock edge sampling key_valid (latency 1 cycle).
REQ-022 Invariant: cursor_x = GRID_X + col*CELL_SIZE, cursor_y = GRID_Y + row*CELL_SIZE every cycle; maintained by +/-CELL_SIZE steps, no multiplier.
REQ-023 Edge, WRAP_EN=0: left at col 0, right at COLS-1, up at row 0, down at ROWS-1 hold all outputs.
REQ-024 Edge, WRAP_EN=1: left at 0 -> COLS-1, right at COLS-1 -> 0; rows analogous; pixel outputs jump consistently.
REQ-025 Enter make with enable=1 -> select_valid=1 the next cycle with select_col/row = col/row at that edge; select_valid is 0 at all other times.
REQ-026 enable=0: FSM still tracks prefixes; moves and Enter are discarded; no pending action replays when enable rises.
REQ-027 key_valid=0: FSM and position hold.

Reset
REQ-028 rst=1 at a clock edge -> FSM IDLE, col=0, row=0, cursor_x=GRID_X, cursor_y=GRID_Y, select_valid=0, select_col=0, select_row=0.
REQ-029 rst has priority over simultaneous key_valid; a prefix byte received before reset is discarded.

Structure
REQ-030 Scan-code constants (E0, F0, 75, 72, 6B, 74, 5A) and the FSM state typedef SHALL live in shared package sea_battle_pkg.
REQ-031 Prefix FSM plus make/break classification SHALL be sub-module ps2_key_decoder, emitting one-cycle move_up/down/left/right and enter strobes.
REQ-032 Elaboration SHALL fail if GRID_X+COLS*CELL_SIZE > 1023 or GRID_Y+ROWS*CELL_SIZE > 1023.

Verification (defaults unless stated)
REQ-033 Reset, then E0,74 -> col=1, cursor_x=350 one cycle after the 74 strobe; then E0,F0,74 -> no change.
REQ-034 WRAP_EN=0, 6B at col 0 -> col=0, cursor_x=320; 74 x12 -> col=9, cursor_x=590.
REQ-035 WRAP_EN=1, 75 at row 0 -> row=9, cursor_y=320; 72 -> row=0, cursor_y=50.
REQ-036 Move to (3,4); 5A -> single-cycle select_valid, select_col=3, select_row=4; F0,5A -> no pulse.
REQ-037 enable=0, 74 and 5A -> no movement, no pulse; enable=1 -> still no pulse.
REQ-038 E0 sent, rst asserted together with 74 -> outputs at reset values; a following bare F0,74 -> ignored as a break.
